// File: rtl/vram_writer.sv
// Host-side pixel write port for shared VRAM: requests are buffered in a FIFO and
// committed with a SETUP/STROBE/HOLD bus cycle only while the display is blanking.
module vram_writer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic [15:0]              REQ_ADDR,
  input  logic [DATA_W-1:0]        REQ_DATA,
  input  logic                     DISP_OE,
  output logic                     MEM_EN,
  output logic [15:0]              MEM_ADDR,
  output logic [DATA_W-1:0]        MEM_DATA,
  output logic                     MEM_WE,
  output logic [$clog2(DEPTH):0]   PENDING
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [15:0]       addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state;
  req_t          fifo [DEPTH];
  req_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign REQ_READY = RST & (count != FULL);
  assign push      = REQ_VALID & REQ_READY;
  // The entry leaves the FIFO only once the strobe is committed, so an abort in SETUP retries it.
  assign pop       = (state == SETUP) & ~DISP_OE;
  assign head      = fifo[rd_ptr];
  assign PENDING   = count;

  always_ff @(posedge CLK) begin
    if (push) fifo[wr_ptr] <= {REQ_ADDR, REQ_DATA};
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      MEM_EN   <= 1'b0;
      MEM_WE   <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
    end else begin
      case (state)
        IDLE: if (count != '0 && !DISP_OE) begin
          state    <= SETUP;
          MEM_EN   <= 1'b1;
          MEM_ADDR <= head.addr;
          MEM_DATA <= head.data;
        end
        SETUP: if (DISP_OE) begin
          state  <= IDLE;
          MEM_EN <= 1'b0;
        end else begin
          state  <= STROBE;
          MEM_WE <= 1'b1;
        end
        STROBE: begin
          state  <= HOLD;
          MEM_WE <= 1'b0;
        end
        HOLD: if (count != '0 && !DISP_OE) begin
          state    <= SETUP;
          MEM_ADDR <= head.addr;
          MEM_DATA <= head.data;
        end else begin
          state  <= IDLE;
          MEM_EN <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          MEM_EN <= 1'b0;
          MEM_WE <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vram_writer.sv
// Scoreboarded bench for vram_writer: accepted requests queue expected writes,
// a negedge monitor checks every VRAM strobe, occupancy and bus-ownership rules.
module tb_vram_writer;
  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic          CLK = 1'b0, RST = 1'b0, REQ_VALID = 1'b0, DISP_OE = 1'b0;
  logic [15:0]   REQ_ADDR = '0;
  logic [DW-1:0] REQ_DATA = '0;
  logic          REQ_READY, MEM_EN, MEM_WE;
  logic [15:0]   MEM_ADDR;
  logic [DW-1:0] MEM_DATA;
  logic [3:0]    PENDING;

  vram_writer #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .DISP_OE(DISP_OE),
    .MEM_EN(MEM_EN), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .MEM_WE(MEM_WE), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  logic [23:0] sb [$];
  int we_cyc [$];
  int cyc = 0, oe_run = 0;
  logic started = 1'b0, rst_q = 1'b0, oe_q = 1'b0;
  logic prev_we = 1'b0;
  logic [23:0] last_ad = '0, exp_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: every accepted request becomes one VRAM write, in acceptance order.
  always @(posedge CLK) begin
    if (!RST) begin
      sb.delete();
      started = 1'b1;
    end else if (REQ_VALID && REQ_READY) begin
      sb.push_back({REQ_ADDR, REQ_DATA});
    end
    oe_q   = DISP_OE;
    oe_run = DISP_OE ? oe_run + 1 : 0;
    rst_q  = !RST;
    cyc++;
  end

  always @(negedge CLK) if (started) begin
    if (rst_q) begin
      chk("rst_mem_en", MEM_EN, 0);
      chk("rst_mem_we", MEM_WE, 0);
      chk("rst_pending", PENDING, 0);
    end
    if (MEM_WE) begin
      chk("we_without_en", MEM_EN, 1);
      chk("addr_data_setup_stable", {MEM_ADDR, MEM_DATA}, last_ad);
      chk("sb_nonempty_on_write", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        chk("write_addr", MEM_ADDR, exp_w[23:8]);
        chk("write_data", MEM_DATA, exp_w[7:0]);
      end
      if (we_cyc.size() != 0) chk("we_spacing_ge3", (cyc - we_cyc[$]) >= 3, 1);
      we_cyc.push_back(cyc);
    end else if (MEM_EN && prev_we) begin
      chk("hold_stable", {MEM_ADDR, MEM_DATA}, last_ad);
    end else if (MEM_EN) begin
      chk("setup_started_under_oe", oe_q, 0);
    end
    chk("pending_vs_model", PENDING, sb.size());
    chk("pending_le_depth", PENDING <= DEPTH, 1);
    chk("en_released_after_oe", MEM_EN && oe_run >= 3, 0);
    prev_we = MEM_WE;
    last_ad = {MEM_ADDR, MEM_DATA};
  end

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    int t = 0;
    forever begin
      @(negedge CLK);
      REQ_VALID = 1'b1;
      if (REQ_READY) begin
        REQ_ADDR = a;
        REQ_DATA = d;
        @(posedge CLK);
        return;
      end
      REQ_ADDR = 16'($urandom);
      REQ_DATA = 8'($urandom);
      t++;
      if (t > 2000) begin
        chk("push_timeout", t, 0);
        REQ_VALID = 1'b0;
        return;
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while ((PENDING != 0 || MEM_EN) && t < 500);
    chk("drain_in_time", t < 500, 1);
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic en_seen;
  logic done;

  initial begin
    // reset state
    repeat (3) @(negedge CLK);
    chk("reset_ready", REQ_READY, 0);
    chk("reset_en", MEM_EN, 0);
    chk("reset_we", MEM_WE, 0);
    chk("reset_addr", MEM_ADDR, 0);
    chk("reset_data", MEM_DATA, 0);
    chk("reset_pending", PENDING, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("ready_after_reset", REQ_READY, 1);

    // single write latency
    push(16'h1234, 8'hA5);
    @(negedge CLK); REQ_VALID = 1'b0;
    chk("t1_k_pending", PENDING, 1);
    chk("t1_k_en", MEM_EN, 0);
    @(negedge CLK);
    chk("t1_k1_en", MEM_EN, 1);
    chk("t1_k1_we", MEM_WE, 0);
    chk("t1_k1_pending", PENDING, 1);
    @(negedge CLK);
    chk("t1_k2_we", MEM_WE, 1);
    chk("t1_k2_addr", MEM_ADDR, 16'h1234);
    chk("t1_k2_data", MEM_DATA, 8'hA5);
    chk("t1_k2_pending", PENDING, 0);
    @(negedge CLK);
    chk("t1_k3_en", MEM_EN, 1);
    chk("t1_k3_we", MEM_WE, 0);
    @(negedge CLK);
    chk("t1_k4_en", MEM_EN, 0);

    // fill and back-pressure
    @(negedge CLK); DISP_OE = 1'b1;
    we_cyc.delete();
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i), 8'(i * 7 + 1));
    @(negedge CLK); REQ_VALID = 1'b0;
    chk("t3_full_pending", PENDING, 8);
    chk("t3_full_ready", REQ_READY, 0);
    fork
      push(16'h0BEE, 8'h99);
      begin
        repeat (4) @(negedge CLK);
        chk("t3_ninth_held", REQ_READY, 0);
        DISP_OE = 1'b0;
      end
    join
    @(negedge CLK); REQ_VALID = 1'b0;
    drain();
    chk("t3_write_count", we_cyc.size(), 9);
    for (int i = 1; i < we_cyc.size(); i++) chk("t3_write_gap", we_cyc[i] - we_cyc[i-1], 3);

    // blanking gate
    @(negedge CLK); DISP_OE = 1'b1;
    for (int i = 0; i < 3; i++) push(16'h2000 + 16'(i), 8'($urandom));
    @(negedge CLK); REQ_VALID = 1'b0;
    en_seen = 1'b0;
    repeat (20) begin @(negedge CLK); en_seen |= MEM_EN; end
    chk("t4_en_gated", en_seen, 0);
    chk("t4_pending", PENDING, 3);
    @(posedge CLK); #1 DISP_OE = 1'b0;
    @(negedge CLK); chk("t4_t_en", MEM_EN, 0);
    @(negedge CLK); chk("t4_t1_setup", MEM_EN, 1);
    drain();

    // abort in SETUP
    we_cyc.delete();
    push(16'hABCD, 8'h5A);
    @(negedge CLK); REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("t5_setup_en", MEM_EN, 1);
    chk("t5_setup_we", MEM_WE, 0);
    DISP_OE = 1'b1;
    @(negedge CLK);
    chk("t5_abort_en", MEM_EN, 0);
    chk("t5_abort_we", MEM_WE, 0);
    chk("t5_abort_pending", PENDING, 1);
    repeat (5) @(negedge CLK);
    DISP_OE = 1'b0;
    drain();
    chk("t5_written_once", we_cyc.size(), 1);

    // late OE rise during STROBE
    we_cyc.delete();
    push(16'h3333, 8'h11);
    push(16'h4444, 8'h22);
    @(negedge CLK); REQ_VALID = 1'b0;
    for (int t = 0; t < 10 && !MEM_WE; t++) @(negedge CLK);
    chk("t6_strobe_reached", MEM_WE, 1);
    DISP_OE = 1'b1;
    @(negedge CLK);
    chk("t6_hold_en", MEM_EN, 1);
    chk("t6_hold_we", MEM_WE, 0);
    @(negedge CLK);
    chk("t6_idle_en", MEM_EN, 0);
    en_seen = 1'b0;
    repeat (6) begin @(negedge CLK); en_seen |= MEM_EN; end
    chk("t6_no_new_setup", en_seen, 0);
    chk("t6_pending", PENDING, 1);
    DISP_OE = 1'b0;
    drain();
    chk("t6_write_count", we_cyc.size(), 2);

    // streaming with wrap
    we_cyc.delete();
    for (int i = 0; i < 20; i++) push(16'($urandom), 8'($urandom));
    @(negedge CLK); REQ_VALID = 1'b0;
    drain();
    chk("t7_write_count", we_cyc.size(), 20);

    // reset mid-stream
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        @(negedge CLK); RST = 1'b0; REQ_VALID = 1'b0;
        @(negedge CLK);
        chk("t7_rst_en", MEM_EN, 0);
        chk("t7_rst_we", MEM_WE, 0);
        chk("t7_rst_pending", PENDING, 0);
        chk("t7_rst_ready", REQ_READY, 0);
        RST = 1'b1;
      end
      push(16'($urandom), 8'($urandom));
    end
    @(negedge CLK); REQ_VALID = 1'b0;
    drain();

    // random OE toggling against a random request stream
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) push(16'($urandom), 8'($urandom));
        @(negedge CLK); REQ_VALID = 1'b0;
        done = 1'b1;
      end
      while (!done) begin
        @(negedge CLK);
        DISP_OE = ($urandom_range(0, 3) == 0);
      end
    join
    DISP_OE = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vram_writer.md
# vram_writer

CPU-side write port for the shared video RAM. It buffers pixel write requests from the host in a small FIFO and commits them to VRAM only while the display pipeline is blanking, that is, while the GPU's display OE is low. It drives the same 16-bit VRAM address space the GPU scans, with address layout {row[7:0], col[7:0]}, so the display reads and this block writes the same memory without bus contention.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; must be a power of two, minimum 2.
- DATA_W, 8: pixel data width.

Ports:
- CLK  in  1  system clock (same domain as the GPU pixel clock).
- RST  in  1  synchronous, active-low reset.
- REQ_VALID  in  1  host write request valid.
- REQ_READY  out  1  block can accept a request.
- REQ_ADDR  in  16  VRAM address {row[7:0], col[7:0]}.
- REQ_DATA  in  DATA_W  pixel value.
- DISP_OE  in  1  GPU display OE; high means the display owns VRAM.
- MEM_EN  out  1  writer owns the VRAM bus and drives address and data.
- MEM_ADDR  out  16  VRAM address.
- MEM_DATA  out  DATA_W  VRAM write data.
- MEM_WE  out  1  active-high write strobe.
- PENDING  out  log2(DEPTH)+1  FIFO occupancy.

## Operation
- **Reset:** one clock and one reset. While RST is low at a rising edge, the next state is:
  - FIFO empty, PENDING=0, state IDLE.
  - MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_DATA=0.
  - REQ_READY is forced low while RST is low.
- **Host handshake:**
  - A request is accepted on any edge where REQ_VALID & REQ_READY.
  - REQ_READY = RST & (PENDING != DEPTH), derived combinationally from registered count only.
  - The host may hold VALID with changing ADDR/DATA while READY is low. Nothing is captured until acceptance.
- **FIFO:**
  - Circular buffer with wrap-around pointers.
  - Push and pop on the same edge leave PENDING unchanged.
  - Push while full cannot occur, because READY is low.
  - Pop only happens on the SETUP→STROBE transition.
- **Write FSM**, with all outputs registered:
  - IDLE: MEM_EN=0, MEM_WE=0. Go to SETUP if PENDING!=0 and DISP_OE==0, loading MEM_ADDR/MEM_DATA from the FIFO head.
  - SETUP: MEM_EN=1, MEM_WE=0. If DISP_OE==1, abort to IDLE with no pop; the entry is retried in the next blanking period. Otherwise pop and go to STROBE.
  - STROBE: MEM_EN=1, MEM_WE=1. Always go to HOLD.
  - HOLD: MEM_EN=1, MEM_WE=0, address and data held.
    - If PENDING!=0 and DISP_OE==0, go directly to SETUP and load the next head.
    - Otherwise go to IDLE.
- **Display-owned exclusivity:**
  - New writes never start while DISP_OE is high.
  - STROBE and HOLD always complete.
  - After DISP_OE rises, MEM_EN deasserts within at most 3 edges. The GPU blanking/porch timing must tolerate this.
- **Ordering and data integrity:**
  - Writes reach VRAM in acceptance order.
  - No entry is lost or duplicated, including across aborts.
- MEM_ADDR/MEM_DATA change only when entering SETUP and are stable through STROBE and HOLD.

## Timing
- **Latency:** request accepted at edge k with FIFO empty, FSM IDLE and DISP_OE low:
  - MEM_EN=1 after edge k+1 (SETUP).
  - MEM_WE=1 after edge k+2.
  - HOLD after edge k+3.
  - IDLE after edge k+4.
- PENDING increments at the accept edge and decrements at the SETUP→STROBE edge.
- **Throughput:** one write per 3 cycles while DISP_OE stays low (SETUP, STROBE, HOLD repeating).
- **Reset mid-write:** the FSM returns to IDLE and MEM_EN/MEM_WE are 0 after the reset edge. Buffered entries are discarded.
- Address/data setup to the WE rising edge is one full cycle; hold after the WE falling edge is one full cycle.

## Test plan
- **Single write:** reset, then DISP_OE=0. Push ADDR=0x1234, DATA=0xA5. Expect:
  - MEM_EN high after edge k+1 and MEM_WE high only in the cycle after edge k+2, with MEM_ADDR=0x1234 and MEM_DATA=0xA5.
  - PENDING sequence 1,1,0.
  - FSM in IDLE after edge k+4.
- **Fill and back-pressure:** DISP_OE=1, push 9 requests with DEPTH=8. Expect:
  - READY low after 8 accepts, PENDING=8, the 9th held until space frees.
  - Drop DISP_OE: 9 writes in order, 3 cycles apart.
- **Blanking gate:** DISP_OE=1 with 3 entries queued. Expect:
  - MEM_EN stays 0 indefinitely.
  - DISP_OE falling at edge t gives SETUP after t+1.
- **Abort in SETUP:** raise DISP_OE in the SETUP cycle. Expect:
  - IDLE next, no WE pulse, PENDING unchanged.
  - The same address/data is written in the next blanking period.
- **Late OE rise:** raise DISP_OE during STROBE. Expect:
  - The write completes (HOLD, then IDLE), MEM_EN=0 within 3 edges, and no new SETUP.
- **Simultaneous push/pop and wrap:** stream 20 writes with DISP_OE=0 and continuous VALID. Expect:
  - PENDING never exceeds DEPTH.
  - Pointers wrap with all 20 writes correct and in order.
  - Reset asserted mid-stream clears MEM_EN/MEM_WE/PENDING on the next edge.
